// File: rtl/vcve2_pkg.sv
// Shared types and constants for the vcve2 EX-side control slice.
package vcve2_pkg;

   localparam int unsigned IMD_VAL_W = 34;

   typedef enum logic {
      EX_IDLE,
      EX_BUSY
   } ex_ctrl_state_e;

endpackage

// File: rtl/vcve2_imd_val_regs.sv
// Two-entry intermediate value register bank, per-entry write enable, async active-low reset.
module vcve2_imd_val_regs #(
   parameter int unsigned Width = 34
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [1:0]              i_we,
   input  logic [1:0][Width-1:0]   i_d,
   output logic [1:0][Width-1:0]   o_q
);

   logic [1:0][Width-1:0] r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (i_we[i]) begin
               r_q[i] <= i_d[i];
            end
         end
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/vcve2_ex_ctrl.sv
// ID-side sequencer for multi-cycle EX ops: enables, stall/done, writeback, intermediate regs.
// Optional watchdog abort of long BUSY periods when VCVE2_EX_WATCHDOG_EN is defined.
module vcve2_ex_ctrl
   import vcve2_pkg::*;
#(
   parameter int unsigned IMD_W      = IMD_VAL_W,
   parameter int unsigned WDOG_LIMIT = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   instr_valid_i,
   input  logic                   mult_sel_i,
   input  logic                   div_sel_i,
   input  logic                   flush_i,
   input  logic                   ex_valid_i,
   input  logic [31:0]            result_ex_i,
   input  logic [1:0]             imd_val_we_i,
   input  logic [1:0][IMD_W-1:0]  imd_val_d_i,
   output logic [1:0][IMD_W-1:0]  imd_val_q_o,
   output logic                   alu_instr_first_cycle_o,
   output logic                   mult_en_o,
   output logic                   div_en_o,
   output logic                   stall_o,
   output logic                   instr_done_o,
   output logic                   wb_valid_o,
   output logic [31:0]            wb_data_o,
   output logic                   wdog_err_o
);

   ex_ctrl_state_e r_state;
   logic           r_mult_sel;
   logic           r_div_sel;
   logic           r_wb_valid;
   logic [31:0]    r_wb_data;

   logic w_is_busy;
   logic w_active;
   logic w_busy_live;
   logic w_wdog_hit;
   logic w_done;

   assign w_is_busy = (r_state == EX_BUSY);
   assign w_active  = (r_state == EX_IDLE) & instr_valid_i & ~flush_i;

`ifdef VCVE2_EX_WATCHDOG_EN
   logic [6:0] r_wdog_cnt;

   assign w_wdog_hit = w_is_busy & ~flush_i & ~ex_valid_i
                       & (r_wdog_cnt == 7'(WDOG_LIMIT - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wdog_cnt <= '0;
      end else if (w_active && !ex_valid_i) begin
         r_wdog_cnt <= '0;
      end else if (w_is_busy) begin
         r_wdog_cnt <= r_wdog_cnt + 7'd1;
      end
   end

   assign wdog_err_o = rst_ni & w_wdog_hit;
`else
   logic w_unused_wdog;

   assign w_unused_wdog = (WDOG_LIMIT == 0);
   assign w_wdog_hit    = 1'b0;
   assign wdog_err_o    = 1'b0;
`endif

   // BUSY work continues unless killed by flush or watchdog in this very cycle.
   assign w_busy_live = w_is_busy & ~flush_i & ~w_wdog_hit;

   // Outputs are gated by rst_ni so they read 0 the moment reset asserts.
   always_comb begin
      w_done                  = 1'b0;
      alu_instr_first_cycle_o = 1'b0;
      mult_en_o               = 1'b0;
      div_en_o                = 1'b0;
      stall_o                 = 1'b0;
      if (rst_ni) begin
         if (w_active) begin
            alu_instr_first_cycle_o = 1'b1;
            mult_en_o               = mult_sel_i;
            div_en_o                = div_sel_i;
            w_done                  = ex_valid_i;
            stall_o                 = ~ex_valid_i;
         end else if (w_busy_live) begin
            mult_en_o = r_mult_sel;
            div_en_o  = r_div_sel;
            w_done    = ex_valid_i;
            stall_o   = ~ex_valid_i;
         end
      end
   end

   assign instr_done_o = w_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= EX_IDLE;
         r_mult_sel <= 1'b0;
         r_div_sel  <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_data  <= '0;
      end else begin
         case (r_state)
            EX_IDLE: begin
               if (w_active && !ex_valid_i) begin
                  r_state    <= EX_BUSY;
                  r_mult_sel <= mult_sel_i;
                  r_div_sel  <= div_sel_i;
               end
            end
            EX_BUSY: begin
               if (flush_i || ex_valid_i || w_wdog_hit) begin
                  r_state <= EX_IDLE;
               end
            end
            default: r_state <= EX_IDLE;
         endcase
         r_wb_valid <= w_done;
         if (w_done) begin
            r_wb_data <= result_ex_i;
         end
      end
   end

   assign wb_valid_o = r_wb_valid;
   assign wb_data_o  = r_wb_data;

   vcve2_imd_val_regs #(
      .Width (IMD_W)
   ) u_imd_val_regs (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_we    (imd_val_we_i),
      .i_d     (imd_val_d_i),
      .o_q     (imd_val_q_o)
   );

endmodule
